// File: rtl/output_module_if.sv
// Bundle for output_module: CPU store side plus the four device-facing output buses.
// master = CPU/devices side, slave = the port block.
interface output_module_if #(
    parameter int WIDTH = 8
);
    logic             we;
    logic [1:0]       sel_port;
    logic [WIDTH-1:0] wdata;
    logic             clr_ovf;
    logic [3:0]       full;
    logic             stall;
    logic [3:0]       ovf;

    logic [WIDTH-1:0] out_p0;
    logic [WIDTH-1:0] out_p1;
    logic [WIDTH-1:0] out_p2;
    logic [WIDTH-1:0] out_p3;
    logic             valid_p0;
    logic             valid_p1;
    logic             valid_p2;
    logic             valid_p3;
    logic             ack_p0;
    logic             ack_p1;
    logic             ack_p2;
    logic             ack_p3;

    modport master (
        output we, sel_port, wdata, clr_ovf,
        output ack_p0, ack_p1, ack_p2, ack_p3,
        input  full, stall, ovf,
        input  out_p0, out_p1, out_p2, out_p3,
        input  valid_p0, valid_p1, valid_p2, valid_p3
    );

    modport slave (
        input  we, sel_port, wdata, clr_ovf,
        input  ack_p0, ack_p1, ack_p2, ack_p3,
        output full, stall, ovf,
        output out_p0, out_p1, out_p2, out_p3,
        output valid_p0, valid_p1, valid_p2, valid_p3
    );
endinterface

// File: rtl/output_module.sv
// Four CPU output ports, each a DEPTH-entry FIFO whose head is presented through a
// registered out/valid pair and consumed by the device with ack.
module output_module #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    output_module_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam cnt_t CNT_TWO  = cnt_t'(2);

    logic [WIDTH-1:0] mem_q    [4][DEPTH];
    logic [WIDTH-1:0] mem_d    [4][DEPTH];
    ptr_t             rd_ptr_q [4];
    ptr_t             rd_ptr_d [4];
    ptr_t             wr_ptr_q [4];
    ptr_t             wr_ptr_d [4];
    cnt_t             count_q  [4];
    cnt_t             count_d  [4];
    logic [WIDTH-1:0] out_q    [4];
    logic [WIDTH-1:0] out_d    [4];
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       full_q,  full_d;
    logic [3:0]       ovf_q,   ovf_d;

    logic [3:0] ack;
    logic [3:0] sel_hit;
    logic [3:0] wr_en;
    logic [3:0] drop;
    logic [3:0] pop;

    // full is the registered flag, so a pop on the same edge never frees room for a write
    always_comb begin
        ack = {bus.ack_p3, bus.ack_p2, bus.ack_p1, bus.ack_p0};
        sel_hit = '0;
        wr_en   = '0;
        drop    = '0;
        pop     = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            sel_hit[n] = bus.we && (bus.sel_port == 2'(n));
            wr_en[n]   = sel_hit[n] && !full_q[n];
            drop[n]    = sel_hit[n] && full_q[n];
            pop[n]     = valid_q[n] && ack[n];
        end
    end

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        valid_d  = valid_q;
        full_d   = full_q;
        for (int unsigned n = 0; n < 4; n++) begin
            if (wr_en[n]) begin
                mem_d[n][wr_ptr_q[n]] = bus.wdata;
                wr_ptr_d[n]           = wr_ptr_q[n] + 1'b1;
            end
            if (pop[n]) begin
                rd_ptr_d[n] = rd_ptr_q[n] + 1'b1;
            end

            unique case ({wr_en[n], pop[n]})
                2'b10:   count_d[n] = count_q[n] + 1'b1;
                2'b01:   count_d[n] = count_q[n] - 1'b1;
                default: count_d[n] = count_q[n];
            endcase

            // Head register: next stored entry on pop, bypass wdata when the FIFO is (becoming) empty
            if (pop[n]) begin
                if (count_q[n] >= CNT_TWO) begin
                    out_d[n] = mem_q[n][rd_ptr_d[n]];
                end else if (wr_en[n]) begin
                    out_d[n] = bus.wdata;
                end
            end else if (wr_en[n] && (count_q[n] == '0)) begin
                out_d[n] = bus.wdata;
            end

            valid_d[n] = (count_d[n] != '0);
            full_d[n]  = (count_d[n] == CNT_FULL);
        end
        ovf_d = drop | (ovf_q & ~{4{bus.clr_ovf}});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            wr_ptr_q <= '{default: '0};
            count_q  <= '{default: '0};
            out_q    <= '{default: '0};
            valid_q  <= '0;
            full_q   <= '0;
            ovf_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.stall    = bus.we & full_q[bus.sel_port];
    assign bus.full     = full_q;
    assign bus.ovf      = ovf_q;
    assign bus.out_p0   = out_q[0];
    assign bus.out_p1   = out_q[1];
    assign bus.out_p2   = out_q[2];
    assign bus.out_p3   = out_q[3];
    assign bus.valid_p0 = valid_q[0];
    assign bus.valid_p1 = valid_q[1];
    assign bus.valid_p2 = valid_q[2];
    assign bus.valid_p3 = valid_q[3];
endmodule

// File: doc/output_module.md
Name: output_module

Overview:
CPU-side output port block: the write-direction counterpart to the CPU's four registered input ports.
- The CPU writes a byte to one of four output ports selected by sel_port.
- Each port buffers writes in a small FIFO and presents them to an external device through a valid/ack handshake.
- Sits between the CPU datapath (store-to-port instruction) and the four external output buses.

Parameters:
WIDTH, 8, data width of every port and of wdata.
DEPTH, 2, entries per port FIFO, including the presented head; power of two, >= 2.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
we  input  1  CPU write strobe, one write per asserted cycle
sel_port  input  2  target port of the write (0..3)
wdata  input  WIDTH  data to write
clr_ovf  input  1  synchronous clear of all overflow flags
full  output  4  per-port FIFO full (count == DEPTH)
stall  output  1  combinational: we & full[sel_port]
ovf  output  4  per-port sticky overflow flags
out_p0..out_p3  output  WIDTH each  presented data per port
valid_p0..valid_p3  output  1 each  port has unconsumed data
ack_p0..ack_p3  input  1 each  device consumes the presented data

Behaviour:
- Reset (async, any time, including mid-transfer):
  - all FIFO counts and pointers go to 0; all entries are discarded.
  - out_pN = 0, valid_pN = 0, full = 0, ovf = 0.
- Per-port count: 0..DEPTH. valid_pN = (count != 0), registered. full[N] = (count == DEPTH), registered.
- Write:
  - accepted on a rising edge when we=1, port N = sel_port and full[N]=0 (value sampled before the edge).
  - Non-selected ports are unaffected.
- Write while full[N]=1:
  - dropped, even if a pop occurs on the same edge (full is not bypassed).
  - ovf[N] is set on that edge.
  - The CPU must honour stall and hold the write.
- Pop: occurs on a rising edge when valid_pN=1 and ack_pN=1. ack_pN while valid_pN=0 is ignored.
- out_pN is a registered copy of the FIFO head:
  - Write into an empty port: out_pN = wdata and valid_pN = 1 after that edge (1-cycle latency).
  - Pop with count >= 2: the next entry appears on out_pN after that edge; valid stays 1.
  - Pop with count == 1 and no write: valid_pN drops. out_pN holds the last popped value (port behaves as a latch when idle).
- Simultaneous write and pop on the same port, count not full:
  - count is unchanged.
  - If count == 1, the written data becomes the head after the edge.
  - Otherwise the written data appends behind the existing entries.
- Ordering: strict FIFO per port. No reordering across or within ports.
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. count is log2(DEPTH)+1 bits.
- ovf[N]:
  - Set by a dropped write. Cleared by clr_ovf on a clock edge.
  - If set and clear happen on the same edge, set wins.
- Sustained throughput: one write and one pop per port per cycle.

Test Plan:
- Reset then idle -> all out_pN = 0x00, valid = 0, full = 0000, ovf = 0000; assert reset mid-stream with port 2 holding 2 entries -> outputs return to 0 immediately (async), count 0 after release.
- Write 0xA5 to port 1, ack_p1 = 0 -> next cycle out_p1 = 0xA5, valid_p1 = 1; other ports stay invalid; pulse ack_p1 for one cycle -> valid_p1 = 0, out_p1 holds 0xA5.
- Write 0x11, 0x22 to port 3 back-to-back with no ack -> full[3] = 1. Third write 0x33 -> stall = 1 that cycle, ovf[3] = 1, data dropped. Two acks -> out_p3 shows 0x11 then 0x22, then valid drops.
- Port 0 holds one entry 0x10; on one edge write 0x20 and ack_p0 = 1 -> out_p0 = 0x20, valid_p0 stays 1, count 1.
- Port 2 full; write plus ack on the same edge -> write dropped, ovf[2] = 1, count goes to 1. clr_ovf on a later edge -> ovf = 0000. clr_ovf together with another dropped write -> ovf[2] remains 1.
- Streaming: write incrementing 0x00..0x0F to port 0 every cycle with ack_p0 held high -> no stall, out_p0 sequence 0x00..0x0F in order, one per cycle, ovf = 0.
